// File: rtl/crc_job_if.sv
// crc_job_if: requester job/data handshake and shared CRC engine bus seen by crc_job_arbiter.
interface crc_job_if;
    logic [1:0]  req;
    logic [63:0] cfg_poly;
    logic [63:0] cfg_init;
    logic [1:0]  cfg_refl;
    logic [1:0]  s_valid;
    logic [1:0]  s_ready;
    logic [1:0]  s_last;
    logic [63:0] s_data;
    logic [7:0]  s_wrl;
    logic [1:0]  done;
    logic [31:0] result;
    logic        busy;
    logic        crc_cs;
    logic [1:0]  crc_rs;
    logic [3:0]  crc_wrl;
    logic [31:0] crc_d;
    logic [31:0] crc_q;

    modport master (
        output req, cfg_poly, cfg_init, cfg_refl, s_valid, s_last, s_data, s_wrl, crc_q,
        input  s_ready, done, result, busy, crc_cs, crc_rs, crc_wrl, crc_d
    );

    modport slave (
        input  req, cfg_poly, cfg_init, cfg_refl, s_valid, s_last, s_data, s_wrl, crc_q,
        output s_ready, done, result, busy, crc_cs, crc_rs, crc_wrl, crc_d
    );
endinterface

// File: rtl/crc_job_arbiter.sv
// crc_job_arbiter: round-robin arbiter sequencing two requesters' CRC jobs onto a shared engine bus.
module crc_job_arbiter (
    input logic      clk,
    input logic      rst,
    crc_job_if.slave bus
);
    typedef enum logic [2:0] {IDLE, POLY, INIT, DATA, WAIT, RESULT} state_t;
    state_t      state;
    logic        g, last_g, last, win, beat, refl;
    logic [31:0] poly, init, data;
    logic [3:0]  wrl_raw, wrl;

    always_comb begin
        win = &bus.req ? ~last_g : bus.req[1];
        refl = bus.cfg_refl[g];
        beat = state == DATA && bus.s_valid[g];
        data = g ? bus.s_data[63:32] : bus.s_data[31:0];
        wrl_raw = g ? bus.s_wrl[7:4] : bus.s_wrl[3:0];
        wrl = wrl_raw inside {4'b0001, 4'b0011} ? wrl_raw : 4'b1111;
        bus.s_ready = state == DATA ? (g ? 2'b10 : 2'b01) : 2'b00;
        bus.busy = state != IDLE;
        bus.crc_cs = beat || state inside {POLY, INIT, WAIT, RESULT};
        bus.crc_rs = state == POLY || state == WAIT ? 2'b01 :
                     beat ? {1'b1, refl} :
                     state == RESULT ? {refl, 1'b0} : 2'b00;
        bus.crc_wrl = state == POLY || state == INIT ? 4'b1111 : beat ? wrl : 4'b0000;
        bus.crc_d = state == POLY ? poly : state == INIT ? init : beat ? data : 32'h0;
    end

    // poly/init are captured at grant so later cfg changes cannot leak into the job
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            g <= 1'b0;
            last_g <= 1'b1;
            last <= 1'b0;
            poly <= 32'h0;
            init <= 32'h0;
            bus.done <= 2'b00;
            bus.result <= 32'h0;
        end else begin
            bus.done <= 2'b00;
            case (state)
                IDLE: if (|bus.req) begin
                    g <= win;
                    poly <= win ? bus.cfg_poly[63:32] : bus.cfg_poly[31:0];
                    init <= win ? bus.cfg_init[63:32] : bus.cfg_init[31:0];
                    state <= POLY;
                end
                POLY: state <= INIT;
                INIT: state <= DATA;
                DATA: if (beat) begin
                    last <= bus.s_last[g];
                    state <= WAIT;
                end
                WAIT: if (bus.crc_q[0]) state <= last ? RESULT : DATA;
                RESULT: begin
                    bus.result <= bus.crc_q;
                    bus.done <= g ? 2'b10 : 2'b01;
                    last_g <= g;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_crc_job_arbiter.sv
// tb_crc_job_arbiter: scoreboard bench with a bit-serial CRC engine model on the shared bus.
`timescale 1ns/1ps
module tb_crc_job_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    crc_job_if bus();
    crc_job_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {int idx; logic [31:0] data; logic [3:0] wrl; logic last; int stall;} beat_t;
    typedef struct {int idx; logic [31:0] res; int lat;} exp_t;
    beat_t bq[$];
    exp_t sb[$];
    exp_t e;
    int checks = 0, errors = 0, cyc = 0, gnt_cyc = 0, ngrant = 0, st = 0, n0 = 0;
    logic hs = 1'b0;
    logic [31:0] e_crc = 32'h0, e_poly = 32'h0;
    int e_cnt = 0;
    int n;

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    function automatic logic [31:0] step(input logic [31:0] c, input logic [31:0] p,
                                         input logic [31:0] d, input int nb, input logic r);
        logic [7:0] b;
        for (int k = 0; k < nb; k++) begin
            b = d[8*k +: 8];
            if (r) b = rev8(b);
            c = c ^ {b, 24'h0};
            for (int j = 0; j < 8; j++) c = c[31] ? ((c << 1) ^ p) : (c << 1);
        end
        return c;
    endfunction

    // engine: status in bit 0 of register 01 rises once every data bit has been shifted
    assign bus.crc_q = bus.crc_rs == 2'b01 ? {31'h0, e_cnt == 0} :
                       bus.crc_rs == 2'b00 ? e_crc :
                       bus.crc_rs == 2'b10 ? rev32(e_crc) : 32'h0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        hs <= |(bus.s_valid & bus.s_ready);
        if (bus.crc_cs && bus.crc_wrl != 4'h0 && bus.crc_rs[1]) begin
            n = bus.crc_wrl == 4'b0001 ? 1 : bus.crc_wrl == 4'b0011 ? 2 : bus.crc_wrl == 4'b1111 ? 4 : 0;
            checks++;
            if (n == 0) begin
                errors++;
                $display("FAIL engine_wrl got %b required 0001/0011/1111", bus.crc_wrl);
            end
            e_crc <= step(e_crc, e_poly, bus.crc_d, n, bus.crc_rs[0]);
            e_cnt <= 8 * n;
        end else begin
            if (bus.crc_cs && bus.crc_wrl != 4'h0 && bus.crc_rs == 2'b00) e_crc <= bus.crc_d;
            if (bus.crc_cs && bus.crc_wrl != 4'h0 && bus.crc_rs == 2'b01) e_poly <= bus.crc_d;
            if (e_cnt != 0) e_cnt <= e_cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (hs && bq.size() != 0) begin
            bq.delete(0);
            st = 0;
        end
        bus.s_valid = 2'b00;
        bus.s_last = 2'b00;
        bus.s_data = 64'h0;
        bus.s_wrl = 8'h0;
        if (bq.size() != 0) begin
            if (st >= bq[0].stall) begin
                bus.s_valid[bq[0].idx] = 1'b1;
                bus.s_last[bq[0].idx] = bq[0].last;
                bus.s_data[bq[0].idx*32 +: 32] = bq[0].data;
                bus.s_wrl[bq[0].idx*4 +: 4] = bq[0].wrl;
            end else if (bus.s_ready[bq[0].idx]) st++;
        end
    end

    always @(negedge clk) begin
        #1;
        if (rst) begin
            checks++;
            if ({bus.done, bus.result, bus.busy, bus.s_ready, bus.crc_cs, bus.crc_rs, bus.crc_wrl, bus.crc_d} != 0) begin
                errors++;
                $display("FAIL reset_out got done=%b result=%h busy=%b s_ready=%b cs=%b rs=%b wrl=%b d=%h required all zero",
                         bus.done, bus.result, bus.busy, bus.s_ready, bus.crc_cs, bus.crc_rs, bus.crc_wrl, bus.crc_d);
            end
        end else begin
            if (bus.done != 2'b00) begin
                checks++;
                if (bus.done == 2'b11) begin
                    errors++;
                    $display("FAIL done_overlap got %b", bus.done);
                end
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected got %b required 00", bus.done);
                end else begin
                    e = sb.pop_front();
                    checks += 3;
                    if (int'(bus.done[1]) != e.idx) begin
                        errors++;
                        $display("FAIL done_idx got %0d required %0d", bus.done[1], e.idx);
                    end
                    if (bus.result != e.res) begin
                        errors++;
                        $display("FAIL result got %h required %h", bus.result, e.res);
                    end
                    if (cyc - gnt_cyc != e.lat) begin
                        errors++;
                        $display("FAIL latency got %0d required %0d", cyc - gnt_cyc, e.lat);
                    end
                end
            end
            checks++;
            if ((!bus.crc_cs || bus.crc_wrl == 4'h0) && bus.crc_d != 32'h0) begin
                errors++;
                $display("FAIL crc_d_idle got %h required 0", bus.crc_d);
            end
            if ((bus.s_ready & ~bus.s_valid) != 2'b00) begin
                checks++;
                if (bus.crc_cs) begin
                    errors++;
                    $display("FAIL stall_cs got 1 required 0");
                end
            end
            if (!bus.busy && bus.req != 2'b00) begin
                gnt_cyc = cyc;
                ngrant++;
            end
        end
    end

    task automatic set_cfg(input int idx, input bit crc32);
        bus.cfg_poly[idx*32 +: 32] = crc32 ? 32'h04C11DB7 : 32'h07000000;
        bus.cfg_init[idx*32 +: 32] = crc32 ? 32'hFFFFFFFF : 32'h0;
        bus.cfg_refl[idx] = crc32;
    endtask

    task automatic add_beat(input int idx, input logic [31:0] d, input logic [3:0] w, input logic l, input int s);
        beat_t b;
        b.idx = idx; b.data = d; b.wrl = w; b.last = l; b.stall = s;
        bq.push_back(b);
    endtask

    task automatic add_exp(input int idx, input logic [31:0] r, input int lat);
        exp_t x;
        x.idx = idx; x.res = r; x.lat = lat;
        sb.push_back(x);
    endtask

    task automatic add_j8(input int idx, input int s, input bit expect_done);
        add_beat(idx, 32'h31, 4'b0001, 1'b1, s);
        if (expect_done) add_exp(idx, 32'h97000000, 14 + s);
    endtask

    task automatic add_j32(input int idx, input int s, input bit bad_wrl);
        add_beat(idx, 32'h34333231, bad_wrl ? 4'b1110 : 4'b1111, 1'b0, s);
        add_beat(idx, 32'h38373635, 4'b1111, 1'b0, s);
        add_beat(idx, 32'h00000039, 4'b0001, 1'b1, s);
        add_exp(idx, 32'h340BC6D9, 82 + 3 * s);
    endtask

    task automatic wait_grants(input int target);
        int t = 0;
        while (ngrant < target && t < 1000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (ngrant < target) begin
            errors++;
            $display("FAIL grant_timeout got %0d required %0d", ngrant, target);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || bq.size() != 0 || bus.busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (sb.size() != 0 || bq.size() != 0 || bus.busy) begin
            errors++;
            $display("FAIL idle_timeout got pending=%0d busy=%b required 0", sb.size(), bus.busy);
        end
    endtask

    task automatic run(input logic [1:0] r);
        int base = ngrant;
        bus.req = r;
        wait_grants(base + 1);
        bus.req = 2'b00;
        wait_idle();
    endtask

    initial begin
        bus.req = 2'b00;
        bus.cfg_poly = 64'h0;
        bus.cfg_init = 64'h0;
        bus.cfg_refl = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        set_cfg(0, 1'b0);
        set_cfg(1, 1'b1);
        add_j8(0, 0, 1'b1);
        add_j32(1, 0, 1'b0);
        add_j8(0, 0, 1'b1);
        add_j32(1, 0, 1'b0);
        n0 = ngrant;
        bus.req = 2'b11;
        wait_grants(n0 + 4);
        bus.req = 2'b00;
        wait_idle();
        add_j32(1, 0, 1'b1);
        run(2'b10);
        set_cfg(0, 1'b1);
        add_j32(0, 1, 1'b0);
        run(2'b01);
        add_j32(0, 5, 1'b0);
        run(2'b01);
        set_cfg(0, 1'b0);
        add_j8(0, 0, 1'b1);
        n0 = ngrant;
        bus.req = 2'b01;
        wait_grants(n0 + 1);
        bus.req = 2'b00;
        bus.cfg_poly[31:0] = 32'hDEADBEEF;
        bus.cfg_init[31:0] = 32'h12345678;
        wait_idle();
        set_cfg(0, 1'b0);
        add_j8(0, 0, 1'b0);
        n0 = ngrant;
        bus.req = 2'b01;
        wait_grants(n0 + 1);
        bus.req = 2'b00;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        add_j8(0, 0, 1'b1);
        run(2'b01);
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
